// File: rtl/gshare_bp_param.sv
// Gshare direction predictor with a direct-mapped BTB and a speculative global history
// that is repaired from the checkpoint returned with a mispredicted instruction.
module gshare_bp_param #(
    parameter int XLEN        = 32,
    parameter int GHR_LEN     = 8,
    parameter int PHT_ENTRIES = 256,
    parameter int CTR_BITS    = 2,
    parameter int BTB_ENTRIES = 64,
    parameter int TAG_BITS    = 12
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    input  logic                req_valid_i,
    input  logic [XLEN-1:0]     req_pc_i,
    output logic                pred_valid_o,
    output logic                pred_taken_o,
    output logic [XLEN-1:0]     pred_target_o,
    output logic [GHR_LEN-1:0]  pred_ghr_o,
    input  logic                upd_valid_i,
    input  logic [XLEN-1:0]     upd_pc_i,
    input  logic                upd_is_branch_i,
    input  logic                upd_taken_i,
    input  logic [XLEN-1:0]     upd_target_i,
    input  logic [GHR_LEN-1:0]  upd_ghr_i,
    input  logic                upd_mispredict_i
);
    localparam int PIDX_W  = $clog2(PHT_ENTRIES);
    localparam int BIDX_W  = $clog2(BTB_ENTRIES);
    localparam int TAG_LSB = BIDX_W + 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

    logic [CTR_BITS-1:0] pht_reg        [PHT_ENTRIES];
    logic                btb_valid_reg  [BTB_ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_reg    [BTB_ENTRIES];
    logic [XLEN-1:0]     btb_target_reg [BTB_ENTRIES];
    logic [GHR_LEN-1:0]  ghr_reg;

    logic                pred_valid_reg;
    logic                pred_taken_reg;
    logic [XLEN-1:0]     pred_target_reg;
    logic [GHR_LEN-1:0]  pred_ghr_reg;

    // Lookup side: combinational reads of the pre-update array contents
    logic [PIDX_W-1:0]   lk_pidx;
    logic [BIDX_W-1:0]   lk_bidx;
    logic [TAG_BITS-1:0] lk_tag;
    logic                lk_hit;
    logic                lk_taken;
    logic [XLEN-1:0]     lk_target;
    logic                repair;
    logic                accept;

    assign lk_pidx   = req_pc_i[PIDX_W+1:2] ^ PIDX_W'(ghr_reg);
    assign lk_bidx   = req_pc_i[BIDX_W+1:2];
    assign lk_tag    = req_pc_i[TAG_LSB +: TAG_BITS];
    assign lk_hit    = btb_valid_reg[lk_bidx] && (btb_tag_reg[lk_bidx] == lk_tag);
    assign lk_taken  = lk_hit && pht_reg[lk_pidx][CTR_BITS-1];
    assign lk_target = lk_taken ? btb_target_reg[lk_bidx] : req_pc_i + XLEN'(4);
    assign repair    = upd_valid_i && upd_mispredict_i;
    assign accept    = req_valid_i && !stall_i && !repair;

    // Update side
    logic [PIDX_W-1:0]   up_pidx;
    logic [BIDX_W-1:0]   up_bidx;
    logic [TAG_BITS-1:0] up_tag;
    logic                up_tag_hit;
    logic [CTR_BITS-1:0] up_ctr;
    logic [CTR_BITS-1:0] up_ctr_next;
    logic                unused_pc_bits;

    assign up_pidx    = upd_pc_i[PIDX_W+1:2] ^ PIDX_W'(upd_ghr_i);
    assign up_bidx    = upd_pc_i[BIDX_W+1:2];
    assign up_tag     = upd_pc_i[TAG_LSB +: TAG_BITS];
    assign up_tag_hit = btb_valid_reg[up_bidx] && (btb_tag_reg[up_bidx] == up_tag);
    assign up_ctr     = pht_reg[up_pidx];
    assign unused_pc_bits = ^{upd_pc_i[1:0], upd_pc_i[XLEN-1:TAG_LSB+TAG_BITS]};

    always_comb begin
        up_ctr_next = up_ctr;
        if (upd_taken_i && up_ctr != CTR_MAX)
            up_ctr_next = up_ctr + 1'b1;
        else if (!upd_taken_i && up_ctr != '0)
            up_ctr_next = up_ctr - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < PHT_ENTRIES; i++) pht_reg[i] <= CTR_INIT;
        end else if (upd_valid_i && upd_is_branch_i) begin
            pht_reg[up_pidx] <= up_ctr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_valid_reg[i] <= 1'b0;
        end else if (upd_valid_i) begin
            if (upd_is_branch_i && upd_taken_i)
                btb_valid_reg[up_bidx] <= 1'b1;
            else if (!upd_is_branch_i && up_tag_hit)
                btb_valid_reg[up_bidx] <= 1'b0;
        end
    end

    // Tag/target need no reset: they are only observed through a set valid bit
    always_ff @(posedge clk_i) begin
        if (!rst_i && upd_valid_i && upd_is_branch_i && upd_taken_i) begin
            btb_tag_reg[up_bidx]    <= up_tag;
            btb_target_reg[up_bidx] <= upd_target_i;
        end
    end

    // Repair wins over a same-cycle speculative shift, and is applied even while stalled
    always_ff @(posedge clk_i) begin
        if (rst_i)
            ghr_reg <= '0;
        else if (repair)
            ghr_reg <= {upd_ghr_i[GHR_LEN-2:0], upd_taken_i};
        else if (accept && lk_hit)
            ghr_reg <= {ghr_reg[GHR_LEN-2:0], lk_taken};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pred_valid_reg  <= 1'b0;
            pred_taken_reg  <= 1'b0;
            pred_target_reg <= '0;
            pred_ghr_reg    <= '0;
        end else if (!stall_i) begin
            pred_valid_reg <= accept;
            if (accept) begin
                pred_taken_reg  <= lk_taken;
                pred_target_reg <= lk_target;
                pred_ghr_reg    <= ghr_reg;
            end
        end
    end

    assign pred_valid_o  = pred_valid_reg;
    assign pred_taken_o  = pred_taken_reg;
    assign pred_target_o = pred_target_reg;
    assign pred_ghr_o    = pred_ghr_reg;
endmodule
